// File: rtl/cv32e40p_if_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_if_instr_queue
// Brief    : DEPTH-entry IF/ID decoupling FIFO. Each entry holds a
//            decompressed instruction, its PC and three status flags.
//            flush_i empties the queue in one cycle.
// Options  : CV32E40P_IF_QUEUE_BYPASS_EN - when defined, an empty queue
//            forwards in_* straight to out_* in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_if_instr_queue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [31:0]      in_pc_i,
  input  logic             in_compressed_i,
  input  logic             in_illegal_c_i,
  input  logic             in_fetch_failed_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_instr_o,
  output logic [31:0]      out_pc_o,
  output logic             out_compressed_o,
  output logic             out_illegal_c_o,
  output logic             out_fetch_failed_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             perf_starve_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 67;

  // Entry layout: {fetch_failed, illegal_c, compressed, pc[31:0], instr[31:0]}
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               empty;
  logic               full;
  logic               bypass;
  logic               bypass_take;
  logic               out_valid;
  logic               push;
  logic               pop;
  logic               wr_en;
  logic               rd_adv;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] out_entry;

  assign in_entry = {in_fetch_failed_i, in_illegal_c_i, in_compressed_i, in_pc_i, in_instr_i};

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

`ifdef CV32E40P_IF_QUEUE_BYPASS_EN
  // An empty queue exposes the incoming entry directly; flush kills it.
  assign bypass = empty & in_valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid   = ~empty | bypass;
  assign head_entry  = bypass ? in_entry : mem_q[rd_ptr_q];

  // Handshakes; flush overrides both sides.
  assign push        = in_valid_i & ~full & ~flush_i;
  assign pop         = out_valid & out_ready_i & ~flush_i;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign bypass_take = bypass & out_ready_i;
  assign wr_en       = push & ~bypass_take;
  assign rd_adv      = pop & ~bypass_take;

  // Next-state for pointers and occupancy; wrap uses an explicit compare.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (rd_adv) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_adv})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Slot storage; not reset because outputs are gated while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // Data outputs are zero whenever no valid head exists.
  assign out_entry          = out_valid ? head_entry : '0;
  assign out_instr_o        = out_entry[31:0];
  assign out_pc_o           = out_entry[63:32];
  assign out_compressed_o   = out_entry[64];
  assign out_illegal_c_o    = out_entry[65];
  assign out_fetch_failed_o = out_entry[66];

  assign out_valid_o   = out_valid;
  assign in_ready_o    = ~full;
  assign count_o       = cnt_q;
  assign empty_o       = empty;
  assign full_o        = full;
  assign perf_starve_o = out_ready_i & ~out_valid;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_if_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_if_instr_queue
// Brief    : Scoreboard bench for cv32e40p_if_instr_queue (DEPTH=3).
//            Understands CV32E40P_IF_QUEUE_BYPASS_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_if_instr_queue;

  localparam int DEPTH = 3;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      in_instr_i;
  logic [31:0]      in_pc_i;
  logic             in_compressed_i;
  logic             in_illegal_c_i;
  logic             in_fetch_failed_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      out_instr_o;
  logic [31:0]      out_pc_o;
  logic             out_compressed_o;
  logic             out_illegal_c_o;
  logic             out_fetch_failed_o;
  logic [CNT_W-1:0] count_o;
  logic             empty_o;
  logic             full_o;
  logic             perf_starve_o;

  cv32e40p_if_instr_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .in_instr_i        (in_instr_i),
    .in_pc_i           (in_pc_i),
    .in_compressed_i   (in_compressed_i),
    .in_illegal_c_i    (in_illegal_c_i),
    .in_fetch_failed_i (in_fetch_failed_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .out_instr_o       (out_instr_o),
    .out_pc_o          (out_pc_o),
    .out_compressed_o  (out_compressed_o),
    .out_illegal_c_o   (out_illegal_c_o),
    .out_fetch_failed_o(out_fetch_failed_o),
    .count_o           (count_o),
    .empty_o           (empty_o),
    .full_o            (full_o),
    .perf_starve_o     (perf_starve_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of entries visible to ID, oldest first.
  // Entry packing (bench-local): {ff, ill, c, pc, instr}.
  logic [66:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 1'b0;
  bit          byp = 1'b0;          // front of exp_q is a same-cycle bypass entry
  bit          push_pending = 1'b0;
  bit          watch_200 = 1'b0;
  bit          seen_200 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares status and head against the model, then retires.
  int          m_sz;
  int          m_stored;
  bit          m_valid;
  logic [66:0] m_head;
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      m_sz     = exp_q.size();
      m_stored = m_sz - int'(byp);
      m_valid  = (m_sz > 0);
      m_head   = m_valid ? exp_q[0] : 67'd0;
      chk("count",       32'(count_o),      32'(m_stored));
      chk("empty",       32'(empty_o),      32'(m_stored == 0));
      chk("full",        32'(full_o),       32'(m_stored == DEPTH));
      chk("in_ready",    32'(in_ready_o),   32'(m_stored < DEPTH));
      chk("out_valid",   32'(out_valid_o),  32'(m_valid));
      chk("perf_starve", 32'(perf_starve_o),32'(out_ready_i && !m_valid));
      chk("out_instr",   out_instr_o,       m_head[31:0]);
      chk("out_pc",      out_pc_o,          m_head[63:32]);
      chk("out_flags",   {29'd0, out_fetch_failed_o, out_illegal_c_o, out_compressed_o},
                         {29'd0, m_head[66:64]});
      if (watch_200 && out_valid_o && out_pc_o == 32'h200) seen_200 = 1'b1;
      if (flush_i) exp_q.delete();
      else if (m_valid && out_ready_i) void'(exp_q.pop_front());
    end
  end

  // One stimulus cycle: drive at posedge+1, decide acceptance at +2,
  // commit the stored push at +6 (after the monitor's negedge at +5).
  task automatic step(input bit v, input bit r, input bit f,
                      input logic [31:0] pc, input logic [31:0] ins, input logic [2:0] fl);
    logic [66:0] e;
    @(posedge clk);
    #1;
    in_valid_i = v;
    out_ready_i = r;
    flush_i = f;
    in_pc_i = pc;
    in_instr_i = ins;
    {in_fetch_failed_i, in_illegal_c_i, in_compressed_i} = fl;
    e = {fl, pc, ins};
    #1;
    byp = 1'b0;
    push_pending = v && !f && (exp_q.size() < DEPTH);
`ifdef CV32E40P_IF_QUEUE_BYPASS_EN
    if (push_pending && exp_q.size() == 0) begin
      exp_q.push_back(e);
      byp = 1'b1;
    end
`endif
    #4;
    if (push_pending && !byp) exp_q.push_back(e);
    push_pending = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
    in_pc_i = '0; in_instr_i = '0;
    in_compressed_i = 1'b0; in_illegal_c_i = 1'b0; in_fetch_failed_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"},     32'(count_o),       32'd0);
    chk({tag, "_empty"},     32'(empty_o),       32'd1);
    chk({tag, "_full"},      32'(full_o),        32'd0);
    chk({tag, "_in_ready"},  32'(in_ready_o),    32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid_o),   32'd0);
    chk({tag, "_starve"},    32'(perf_starve_o), 32'd0);
    chk({tag, "_instr"},     out_instr_o,        32'd0);
    chk({tag, "_pc"},        out_pc_o,           32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    check_reset_state("rst_init");
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Fill to full with ID stalled, one extra held-off push, then drain.
    for (int i = 0; i < DEPTH; i++)
      step(1, 0, 0, 32'h100 + 32'(4 * i), 32'h13 + 32'(i), 3'(i));
    step(1, 0, 0, 32'h10C, 32'h99, 3'b111);
    for (int i = 0; i < DEPTH + 1; i++)
      step(0, 1, 0, 32'h0, 32'h0, 3'b000);

    // Wrap-around: one entry primed, then ten concurrent push/pop pairs.
    step(1, 0, 0, 32'h300, 32'h13, 3'b000);
    for (int i = 1; i <= 10; i++)
      step(1, 1, 0, 32'h300 + 32'(4 * i), 32'h13 + 32'(i), 3'b001);
    step(0, 1, 0, 32'h0, 32'h0, 3'b000);
    step(0, 1, 0, 32'h0, 32'h0, 3'b000);

    // Full with concurrent pop: push held off, accepted next cycle.
    for (int i = 0; i < DEPTH; i++)
      step(1, 0, 0, 32'h400 + 32'(4 * i), 32'h50 + 32'(i), 3'b010);
    step(1, 1, 0, 32'h40C, 32'h53, 3'b100);
    step(1, 0, 0, 32'h40C, 32'h53, 3'b100);
    for (int i = 0; i < DEPTH + 1; i++)
      step(0, 1, 0, 32'h0, 32'h0, 3'b000);

    // Flush with concurrent push: PC 0x200 must never surface.
    step(1, 0, 0, 32'h500, 32'h60, 3'b000);
    step(1, 0, 0, 32'h504, 32'h61, 3'b000);
    watch_200 = 1'b1;
    step(1, 0, 1, 32'h200, 32'h62, 3'b000);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 32'h0, 32'h0, 3'b000);
    watch_200 = 1'b0;
    chk("flush_drop_0x200", 32'(seen_200), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
           $urandom, $urandom, 3'($urandom));

    // Mid-operation asynchronous reset with two entries held.
    step(0, 0, 1, 32'h0, 32'h0, 3'b000);
    step(1, 0, 0, 32'h600, 32'h70, 3'b000);
    step(1, 0, 0, 32'h604, 32'h71, 3'b000);
    @(posedge clk);
    #1 idle_inputs();
    #2 rst = 1'b1;
    exp_q.delete();
    byp = 1'b0;
    #1;
    check_reset_state("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, $urandom, $urandom, 3'($urandom));
    step(0, 0, 0, 32'h0, 32'h0, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv32e40p_if_instr_queue.md
# cv32e40p_if_instr_queue

Parametrised IF/ID decoupling queue that replaces the single IF/ID pipeline register of the fetch stage with a DEPTH-entry FIFO of decoded-ready instructions. It sits between the aligner/compressed decoder (push side) and the ID stage (pop side). Its purpose is to let fetch run ahead while ID stalls, and to absorb single-cycle ID hiccups without throttling the prefetch buffer. Each entry carries the 32-bit decompressed instruction, its PC and three status flags. On a PC set, the whole queue is flushed in one cycle.

## Interface
Parameters:
- DEPTH, 2, number of entries; legal range 2..16; any integer, power of two not required.
- CNT_W, $clog2(DEPTH+1), width of count_o; derived, not to be overridden.

Ports (reset is one clock, asynchronous, active-high):
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- flush_i  in  1  drop all entries (driven by pc_set); takes priority over push and pop.
- in_valid_i  in  1  push request from aligner/decoder.
- in_ready_o  out  1  queue can accept a push this cycle.
- in_instr_i  in  32  decompressed instruction.
- in_pc_i  in  32  instruction PC.
- in_compressed_i  in  1  instruction was RVC.
- in_illegal_c_i  in  1  illegal compressed encoding.
- in_fetch_failed_i  in  1  fetch error flag.
- out_valid_o  out  1  head entry valid toward ID.
- out_ready_i  in  1  ID consumes the head; equals id_ready & ~halt_if.
- out_instr_o  out  32  head instruction.
- out_pc_o  out  32  head PC.
- out_compressed_o  out  1  head RVC flag.
- out_illegal_c_o  out  1  head illegal-RVC flag.
- out_fetch_failed_o  out  1  head fetch-failed flag.
- count_o  out  CNT_W  number of valid entries.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.
- perf_starve_o  out  1  out_ready_i & ~out_valid_o; ID wanted an instruction and none was available.

## Operation
- Storage: DEPTH slots of 67 bits each. Read pointer rd_ptr, write pointer wr_ptr, occupancy cnt.
- Pointer wrap: each pointer increments and resets to 0 after reaching DEPTH-1. The wrap is an explicit compare, never a power-of-two mask.
- Push fires when in_valid_i & in_ready_o & ~flush_i.
- Pop fires when out_valid_o & out_ready_i & ~flush_i.
- cnt update:
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop together: cnt unchanged.
  - flush: cnt=0, rd_ptr=wr_ptr=0.
- in_ready_o = ~full_o. It does not look ahead at a same-cycle pop.
- out_valid_o = ~empty_o.
- While out_valid_o is 0, all out_* data outputs are forced to 0.
- Push while full cannot happen because in_ready_o is 0. An in_valid_i asserted while full is simply held off; nothing is dropped and nothing is flagged as an error.
- Pop while empty cannot happen because out_valid_o is 0. out_ready_i alone has no effect.
- Flush in the same cycle as an in_valid_i push: the pushed entry is discarded and the queue is empty on the next cycle.
- Mid-operation reset: the asynchronous assertion of rst immediately clears pointers and cnt and forces all outputs to their reset values. Slot contents are not reset; they are unobservable because the data outputs are gated.

## Timing
- Reset values:
  - out_valid_o=0, in_ready_o=1, empty_o=1, full_o=0, count_o=0, perf_starve_o=0.
  - All out_* data outputs are 0.
- Push-to-out latency: 1 cycle. An entry written at edge N is presented at out_* after edge N.
- Pop: the head advances on the edge where the pop fires. The next entry, if any, is valid in the following cycle with no bubble.
- Flush: effective at the next edge. out_valid_o is 0 in the cycle after flush_i.
- Full throughput: with DEPTH ≥ 2 and both sides always active, one push and one pop occur per cycle.
- Output timing: all outputs except perf_starve_o come from registers or from register-plus-gating logic. No combinational path exists from in_* to out_*, unless the feature below is enabled.

## Configuration
- Macro: CV32E40P_IF_QUEUE_BYPASS_EN.
- Defined:
  - When the queue is empty and in_valid_i=1, out_valid_o=1 and out_* take the in_* values combinationally in the same cycle.
  - If out_ready_i=1 in that cycle, the entry is consumed directly and is not written to storage; cnt stays 0.
  - flush_i=1 suppresses the bypass: out_valid_o=0.
  - Push-to-out latency becomes 0.
- Undefined: no bypass; latency is 1 as specified in Timing.

## Test plan
- Reset and idle: assert rst mid-cycle with 2 entries held, release it -> count_o=0, empty_o=1, in_ready_o=1, out_instr_o=0 immediately.
- Fill and drain, DEPTH=3: push PCs 0x100, 0x104, 0x108 with out_ready_i=0 -> full_o=1, in_ready_o=0. Then pop 3 times -> out_pc_o goes 0x100, 0x104, 0x108, then out_valid_o=0.
- Wrap-around, DEPTH=3: run 10 push/pop pairs with incrementing instr 0x13, 0x14, … -> FIFO order preserved, count_o constant at 1.
- Simultaneous push and pop at full, DEPTH=2: pop fires and in_ready_o=0, so no push occurs -> count_o=1 on the next cycle, and the held input is accepted one cycle later.
- Flush with concurrent push: queue holds 2 entries, flush_i=1 and in_valid_i=1 -> the next cycle shows count_o=0, out_valid_o=0, and the pushed PC 0x200 never appears.
- Bypass (macro defined): empty queue, in_valid_i=1, out_ready_i=1, in_pc_i=0x80 -> out_pc_o=0x80 in the same cycle, count_o stays 0. Without the macro, 0x80 appears one cycle later.
